// File: rtl/vga_timing_pkg.sv
// 640x480@60Hz VGA raster constants and sync polarity shared with the colour stage.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Active level of each sync output; 0 means active-low.
    localparam logic H_POL = 1'b0;
    localparam logic V_POL = 1'b0;

    function automatic logic in_window(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..MAX on enable, exposes the next value and the wrap flag.
module vga_axis_counter #(
    parameter int W   = 10,
    parameter int MAX = 799
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_next,
    output logic         o_wrap
);

    localparam logic [W-1:0] L_MAX = W'(MAX);

    logic [W-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en && (r_cnt == L_MAX);

    always_comb begin
        o_next = r_cnt;
        if (o_wrap)
            o_next = '0;
        else if (i_en)
            o_next = r_cnt + 1'b1;
    end

    // Reset parks the counter on its last value so the first enable lands on 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= L_MAX;
        else
            r_cnt <= o_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; define VGA_FRAME_CNT_EN to add the 16-bit o_frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic H_POL    = vga_timing_pkg::H_POL,
    parameter logic V_POL    = vga_timing_pkg::V_POL,
    parameter int   COORD_W  = 10
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_active,
    output logic               o_line_end,
    output logic               o_animate
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]        o_frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > (1 << COORD_W)) || (V_TOTAL > (1 << COORD_W))) begin : g_bad_coord_w
        $error("vga_timing_gen: COORD_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_v_en;

    logic r_hsync;
    logic r_vsync;
    logic r_active;
    logic r_line_end;
    logic r_animate;

    assign w_v_en = i_pix_stb & w_h_wrap;

    vga_axis_counter #(
        .W   (COORD_W),
        .MAX (H_TOTAL - 1)
    ) u_h_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_pix_stb),
        .o_cnt  (o_x),
        .o_next (w_x_next),
        .o_wrap (w_h_wrap)
    );

    vga_axis_counter #(
        .W   (COORD_W),
        .MAX (V_TOTAL - 1)
    ) u_v_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_v_en),
        .o_cnt  (o_y),
        .o_next (w_y_next),
        .o_wrap (w_v_wrap)
    );

    // Decoding the next counter values keeps every flag aligned with o_x/o_y; without a strobe
    // the next values equal the current ones, so levels hold and the wrap-driven pulses fall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hsync    <= ~H_POL;
            r_vsync    <= ~V_POL;
            r_active   <= 1'b0;
            r_line_end <= 1'b0;
            r_animate  <= 1'b0;
        end else begin
            r_hsync    <= in_window(int'(w_x_next), H_ACTIVE + H_FP, H_SYNC) ? H_POL : ~H_POL;
            r_vsync    <= in_window(int'(w_y_next), V_ACTIVE + V_FP, V_SYNC) ? V_POL : ~V_POL;
            r_active   <= (int'(w_x_next) < H_ACTIVE) && (int'(w_y_next) < V_ACTIVE);
            r_line_end <= w_h_wrap;
            r_animate  <= w_h_wrap && (int'(w_y_next) == V_ACTIVE);
        end
    end

    assign o_hsync    = r_hsync;
    assign o_vsync    = r_vsync;
    assign o_active   = r_active;
    assign o_line_end = r_line_end;
    assign o_animate  = r_animate;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_frame_cnt <= 16'd0;
        else if (w_v_wrap)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign o_frame_cnt = r_frame_cnt;
`else
    logic w_unused_v_wrap;
    assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 instance plus a 16x11 raster instance (active-high hsync) for frame-level checks.
module tb_vga_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       stb_f;
    logic       stb_s;

    logic [9:0] fx, fy, sx, sy;
    logic       fhs, fvs, fact, fle, fan;
    logic       shs, svs, sact, sle, san;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] ffc, sfc;
`endif

    int total = 0;
    int bad   = 0;
    int ex, ey, mx, my;
    logic exp_hs, exp_vs, exp_act, exp_le, exp_an;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pix_stb   (stb_f),
        .o_hsync     (fhs),
        .o_vsync     (fvs),
        .o_x         (fx),
        .o_y         (fy),
        .o_active    (fact),
        .o_line_end  (fle),
        .o_animate   (fan)
`ifdef VGA_FRAME_CNT_EN
        ,
        .o_frame_cnt (ffc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2),
        .H_POL    (1'b1),
        .V_POL    (1'b0),
        .COORD_W  (10)
    ) dut_s (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pix_stb   (stb_s),
        .o_hsync     (shs),
        .o_vsync     (svs),
        .o_x         (sx),
        .o_y         (sy),
        .o_active    (sact),
        .o_line_end  (sle),
        .o_animate   (san)
`ifdef VGA_FRAME_CNT_EN
        ,
        .o_frame_cnt (sfc)
`endif
    );

    // One clock cycle; strobes are driven mid-cycle and outputs are observed 2 ns after the edge.
    task automatic step(input logic sf, input logic ss);
        stb_f = sf;
        stb_s = ss;
        @(posedge clk);
        #2;
        stb_f = 1'b0;
        stb_s = 1'b0;
        if (sf) begin
            ex = ex + 1;
            if (ex == 800) begin
                ex = 0;
                ey = (ey == 524) ? 0 : ey + 1;
            end
        end
        if (ss) begin
            mx = mx + 1;
            if (mx == 16) begin
                mx = 0;
                my = (my == 10) ? 0 : my + 1;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        stb_f = 1'b0;
        stb_s = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (fx !== 10'd799)  begin bad++; $display("FAIL reset_x got=%0d want=799", fx); end
        total++; if (fy !== 10'd524)  begin bad++; $display("FAIL reset_y got=%0d want=524", fy); end
        total++; if ({fhs, fvs} !== 2'b11) begin bad++; $display("FAIL reset_sync got=%b%b want=11", fhs, fvs); end
        total++; if ({fact, fle, fan} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b%b%b want=000", fact, fle, fan); end
        total++; if ({sx, sy} !== {10'd15, 10'd10}) begin bad++; $display("FAIL reset_small_xy got=%0d,%0d want=15,10", sx, sy); end
        total++; if ({shs, svs} !== 2'b01) begin bad++; $display("FAIL reset_small_sync got=%b%b want=01", shs, svs); end
`ifdef VGA_FRAME_CNT_EN
        total++; if (ffc !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", ffc); end
`endif
        rst = 1'b0;
        ex = 799; ey = 524; mx = 15; my = 10;
        step(1'b1, 1'b1);
        total++; if ({fx, fy} !== 20'd0) begin bad++; $display("FAIL first_strobe_xy got=%0d,%0d want=0,0", fx, fy); end
        total++; if ({fact, fle, fan, fhs, fvs} !== 5'b11011) begin bad++; $display("FAIL first_strobe_flags got=%b%b%b%b%b want=11011", fact, fle, fan, fhs, fvs); end
        total++; if ({sx, sy, sle, shs} !== {10'd0, 10'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL first_strobe_small got=%0d,%0d le=%b hs=%b want=0,0 le=1 hs=0", sx, sy, sle, shs); end
`ifdef VGA_FRAME_CNT_EN
        total++; if (ffc !== 16'd1) begin bad++; $display("FAIL first_strobe_frame_cnt got=%0d want=1", ffc); end
`endif
        step(1'b0, 1'b0);
        total++; if ({fx, fy, fact, fle} !== {10'd0, 10'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL idle_hold got=%0d,%0d act=%b le=%b want=0,0 act=1 le=0", fx, fy, fact, fle); end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int act_low = 0;
        int le_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b1, 1'b0);
            exp_hs  = !(ex >= 656 && ex <= 751);
            exp_act = (ex < 640) && (ey < 480);
            exp_le  = (ex == 0);
            total++;
            if ({fx, fy, fhs, fvs, fact, fle, fan} !== {10'(ex), 10'(ey), exp_hs, 1'b1, exp_act, exp_le, 1'b0}) begin
                bad++;
                $display("FAIL line_pixel got=(%0d,%0d) hs=%b vs=%b act=%b le=%b an=%b want=(%0d,%0d) hs=%b vs=1 act=%b le=%b an=0",
                         fx, fy, fhs, fvs, fact, fle, fan, ex, ey, exp_hs, exp_act, exp_le);
            end
            if (!fhs) hs_low++;
            if (!fact) act_low++;
            if (fle) le_cnt++;
        end
        total++; if (hs_low != 96)  begin bad++; $display("FAIL line_hsync_width got=%0d want=96", hs_low); end
        total++; if (act_low != 160) begin bad++; $display("FAIL line_blank_width got=%0d want=160", act_low); end
        total++; if (le_cnt != 1)   begin bad++; $display("FAIL line_end_count got=%0d want=1", le_cnt); end
        total++; if ({fx, fy} !== {10'd0, 10'd1}) begin bad++; $display("FAIL line_end_pos got=%0d,%0d want=0,1", fx, fy); end
    endtask

    task automatic test_strobe_rate();
        for (int i = 0; i < 900; i++) begin
            step(1'b1, 1'b0);
            exp_hs  = !(ex >= 656 && ex <= 751);
            exp_act = (ex < 640) && (ey < 480);
            exp_le  = (ex == 0);
            total++;
            if ({fx, fy, fhs, fact, fle} !== {10'(ex), 10'(ey), exp_hs, exp_act, exp_le}) begin
                bad++;
                $display("FAIL rate_strobe got=(%0d,%0d) hs=%b act=%b le=%b want=(%0d,%0d) hs=%b act=%b le=%b",
                         fx, fy, fhs, fact, fle, ex, ey, exp_hs, exp_act, exp_le);
            end
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b0);
                total++;
                if ({fx, fy, fhs, fact, fle, fan} !== {10'(ex), 10'(ey), exp_hs, exp_act, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL rate_hold got=(%0d,%0d) hs=%b act=%b le=%b an=%b want=(%0d,%0d) hs=%b act=%b le=0 an=0",
                             fx, fy, fhs, fact, fle, fan, ex, ey, exp_hs, exp_act);
                end
            end
        end
        total++; if ({fx, fy} !== {10'd100, 10'd2}) begin bad++; $display("FAIL rate_end_pos got=%0d,%0d want=100,2", fx, fy); end
    endtask

    task automatic test_frame_small();
        int an_cnt = 0;
        int vs_low = 0;
        int le_cnt = 0;
        for (int i = 0; i < 352; i++) begin
            step(1'b0, 1'b1);
            exp_hs  = (mx >= 10 && mx <= 12);
            exp_vs  = !(my >= 7 && my <= 8);
            exp_act = (mx < 8) && (my < 6);
            exp_le  = (mx == 0);
            exp_an  = (mx == 0) && (my == 6);
            total++;
            if ({sx, sy, shs, svs, sact, sle, san} !== {10'(mx), 10'(my), exp_hs, exp_vs, exp_act, exp_le, exp_an}) begin
                bad++;
                $display("FAIL frame_pixel got=(%0d,%0d) hs=%b vs=%b act=%b le=%b an=%b want=(%0d,%0d) hs=%b vs=%b act=%b le=%b an=%b",
                         sx, sy, shs, svs, sact, sle, san, mx, my, exp_hs, exp_vs, exp_act, exp_le, exp_an);
            end
            if (san) an_cnt++;
            if (!svs) vs_low++;
            if (sle) le_cnt++;
        end
        total++; if (an_cnt != 2)  begin bad++; $display("FAIL frame_animate_count got=%0d want=2", an_cnt); end
        total++; if (vs_low != 64) begin bad++; $display("FAIL frame_vsync_width got=%0d want=64", vs_low); end
        total++; if (le_cnt != 22) begin bad++; $display("FAIL frame_line_end_count got=%0d want=22", le_cnt); end
        total++; if ({sx, sy} !== 20'd0) begin bad++; $display("FAIL frame_end_pos got=%0d,%0d want=0,0", sx, sy); end
`ifdef VGA_FRAME_CNT_EN
        total++; if (sfc !== 16'd3) begin bad++; $display("FAIL frame_cnt got=%0d want=3", sfc); end
`endif
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 700; i++)
            step(1'b1, (i >= 604));
        total++; if ({fx, fy, fle} !== {10'd0, 10'd3, 1'b1}) begin bad++; $display("FAIL pre_reset_full got=%0d,%0d le=%b want=0,3 le=1", fx, fy, fle); end
        total++; if ({sx, sy, sle, san} !== {10'd0, 10'd6, 1'b1, 1'b1}) begin bad++; $display("FAIL pre_reset_small got=%0d,%0d le=%b an=%b want=0,6 le=1 an=1", sx, sy, sle, san); end
        #3;
        rst = 1'b1;
        #1;
        total++; if ({fx, fy} !== {10'd799, 10'd524}) begin bad++; $display("FAIL async_reset_xy got=%0d,%0d want=799,524", fx, fy); end
        total++; if ({fhs, fvs, fact, fle, fan} !== 5'b11000) begin bad++; $display("FAIL async_reset_flags got=%b%b%b%b%b want=11000", fhs, fvs, fact, fle, fan); end
        total++; if ({sx, sy, shs, svs, sact, sle, san} !== {10'd15, 10'd10, 5'b01000}) begin bad++; $display("FAIL async_reset_small got=%0d,%0d flags=%b%b%b%b%b want=15,10 flags=01000", sx, sy, shs, svs, sact, sle, san); end
`ifdef VGA_FRAME_CNT_EN
        total++; if (ffc !== 16'd0) begin bad++; $display("FAIL async_reset_frame_cnt got=%0d want=0", ffc); end
`endif
        @(posedge clk);
        #2;
        total++; if ({fle, fan, sle, san} !== 4'b0000) begin bad++; $display("FAIL reset_no_pulse got=%b%b%b%b want=0000", fle, fan, sle, san); end
        rst = 1'b0;
        ex = 799; ey = 524; mx = 15; my = 10;
        step(1'b1, 1'b1);
        total++; if ({fx, fy, fle, sx, sy} !== {10'd0, 10'd0, 1'b1, 10'd0, 10'd0}) begin bad++; $display("FAIL post_reset_strobe got=%0d,%0d le=%b small=%0d,%0d want=0,0 le=1 small=0,0", fx, fy, fle, sx, sy); end
    endtask

    initial begin
        rst   = 1'b1;
        stb_f = 1'b0;
        stb_s = 1'b0;
        test_reset();
        test_line();
        test_strobe_rate();
        test_frame_small();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
